// File: rtl/risc_pipe_pkg.sv
// Shared constants and encodings for the integer pipeline stages.
package risc_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 12;
  localparam int ALU_SEL_W  = 5;

  // EX operand mux select: where the operand value comes from.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  // ALU SELECT codes understood by the EX-stage ALU.
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_SLL  = 5'b00010,
    ALU_SLT  = 5'b00011,
    ALU_SLTU = 5'b00100,
    ALU_XOR  = 5'b00101,
    ALU_SRL  = 5'b00110,
    ALU_SRA  = 5'b00111,
    ALU_OR   = 5'b01000,
    ALU_AND  = 5'b01001
  } alu_sel_e;

endpackage

// File: rtl/ex_forward_ctrl.sv
// Forward-select generator for one EX operand. Looks at the producer about
// to enter MEM (currently in EX) and the producer about to enter WB
// (currently in MEM); the younger one wins.
module ex_forward_ctrl #(
  parameter int REG_ADDR_W = risc_pipe_pkg::REG_ADDR_W
) (
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output logic [1:0]            sel_o
);
  import risc_pipe_pkg::*;

  logic addr_live;
  logic ex_hit;
  logic mem_hit;

  // Loads in EX have no ALU result yet; those are covered by the stall path.
  always_comb begin
    addr_live = uses_i && (addr_i != '0);
    ex_hit    = ex_valid_i && ex_reg_write_i && !ex_mem_read_i && (ex_rd_i == addr_i);
    mem_hit   = mem_reg_write_i && (mem_rd_i == addr_i);
    sel_o     = FWD_REGFILE;
    if (addr_live) begin
      if (ex_hit) begin
        sel_o = FWD_EXMEM;
      end else if (mem_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded operands and control for EX,
// inserts a bubble on flush or load-use hazard, bypasses same-cycle WB
// writes into the captured operands and registers EX forwarding selects.
module id_ex_pipeline_reg #(
  parameter int XLEN       = risc_pipe_pkg::XLEN,
  parameter int REG_ADDR_W = risc_pipe_pkg::REG_ADDR_W,
  parameter int CTRL_W     = risc_pipe_pkg::CTRL_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  uses_rs1_i,
  input  logic                  uses_rs2_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [4:0]            alu_select_i,
  input  logic                  mem_read_i,
  input  logic                  reg_write_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_reg_write_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [4:0]            alu_select_o,
  output logic                  mem_read_o,
  output logic                  reg_write_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [1:0]            fwd1_sel_o,
  output logic [1:0]            fwd2_sel_o
);
  import risc_pipe_pkg::*;

  logic                  valid_q,      valid_d;
  logic [XLEN-1:0]       pc_q,         pc_d;
  logic [XLEN-1:0]       rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]       imm_q,        imm_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [4:0]            alu_select_q, alu_select_d;
  logic                  mem_read_q,   mem_read_d;
  logic                  reg_write_q,  reg_write_d;
  logic [CTRL_W-1:0]     ctrl_q,       ctrl_d;
  logic [1:0]            fwd1_sel_q,   fwd1_sel_d;
  logic [1:0]            fwd2_sel_q,   fwd2_sel_d;

  logic       hazard;
  logic       bubble;
  logic       rs1_wb_hit;
  logic       rs2_wb_hit;
  logic [1:0] fwd1_cap;
  logic [1:0] fwd2_cap;

  ex_forward_ctrl #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .uses_i          (uses_rs1_i),
    .addr_i          (rs1_addr_i),
    .ex_valid_i      (valid_q),
    .ex_reg_write_i  (reg_write_q),
    .ex_mem_read_i   (mem_read_q),
    .ex_rd_i         (rd_q),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_rd_i        (mem_rd_i),
    .sel_o           (fwd1_cap)
  );

  ex_forward_ctrl #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .uses_i          (uses_rs2_i),
    .addr_i          (rs2_addr_i),
    .ex_valid_i      (valid_q),
    .ex_reg_write_i  (reg_write_q),
    .ex_mem_read_i   (mem_read_q),
    .ex_rd_i         (rd_q),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_rd_i        (mem_rd_i),
    .sel_o           (fwd2_cap)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = valid_q && mem_read_q && (rd_q != '0) && valid_i &&
             ((uses_rs1_i && (rs1_addr_i == rd_q)) ||
              (uses_rs2_i && (rs2_addr_i == rd_q)));
    bubble = flush_i || hazard;
    // A flush already discards the ID instruction, so no need to hold IF/ID for it.
    stall_o = hold_i || (hazard && !flush_i);
  end

  // WB writes landing this cycle have not reached the regfile read port yet.
  always_comb begin
    rs1_wb_hit = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs1_addr_i);
    rs2_wb_hit = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs2_addr_i);
  end

  // Next-state selection: hold, bubble or capture.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rd_d         = rd_q;
    alu_select_d = alu_select_q;
    mem_read_d   = mem_read_q;
    reg_write_d  = reg_write_q;
    ctrl_d       = ctrl_q;
    fwd1_sel_d   = fwd1_sel_q;
    fwd2_sel_d   = fwd2_sel_q;
    if (!hold_i) begin
      if (bubble) begin
        valid_d      = 1'b0;
        pc_d         = '0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        rd_d         = '0;
        alu_select_d = ALU_ADD;
        mem_read_d   = 1'b0;
        reg_write_d  = 1'b0;
        ctrl_d       = '0;
        fwd1_sel_d   = FWD_REGFILE;
        fwd2_sel_d   = FWD_REGFILE;
      end else begin
        valid_d      = valid_i;
        pc_d         = pc_i;
        rs1_data_d   = rs1_wb_hit ? wb_data_i : rs1_data_i;
        rs2_data_d   = rs2_wb_hit ? wb_data_i : rs2_data_i;
        imm_d        = imm_i;
        rd_d         = rd_i;
        alu_select_d = alu_select_i;
        mem_read_d   = mem_read_i;
        reg_write_d  = reg_write_i;
        ctrl_d       = ctrl_i;
        fwd1_sel_d   = fwd1_cap;
        fwd2_sel_d   = fwd2_cap;
      end
    end
  end

  // Stage register with synchronous reset to an empty slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      alu_select_q <= ALU_ADD;
      mem_read_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      ctrl_q       <= '0;
      fwd1_sel_q   <= FWD_REGFILE;
      fwd2_sel_q   <= FWD_REGFILE;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      alu_select_q <= alu_select_d;
      mem_read_q   <= mem_read_d;
      reg_write_q  <= reg_write_d;
      ctrl_q       <= ctrl_d;
      fwd1_sel_q   <= fwd1_sel_d;
      fwd2_sel_q   <= fwd2_sel_d;
    end
  end

  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign rd_o         = rd_q;
  assign alu_select_o = alu_select_q;
  assign mem_read_o   = mem_read_q;
  assign reg_write_o  = reg_write_q;
  assign ctrl_o       = ctrl_q;
  assign fwd1_sel_o   = fwd1_sel_q;
  assign fwd2_sel_o   = fwd2_sel_q;

endmodule
